// File: rtl/osd_pkg.sv
// Shared OSD glyph definitions: geometry, ROM layout, FSM states, descriptor struct.
package osd_pkg;

    localparam int unsigned PAGES         = 2;
    localparam int unsigned PNG_W         = 64;
    localparam int unsigned PNG_H         = 64;
    localparam int unsigned MSB_BPP       = 8;
    localparam int unsigned LAST_CHAR     = 383;
    localparam int unsigned CHAR_ENCODING = 12;
    localparam int unsigned CE            = CHAR_ENCODING;

    localparam int unsigned FIRST_CHAR  = 32;
    localparam int unsigned DESC_STRIDE = 6;
    localparam int unsigned DESC_W      = 5 * CE;
    localparam int unsigned DA_W        = $clog2((LAST_CHAR - 31) * DESC_STRIDE);
    localparam int unsigned PA_W        = $clog2(PAGES * PNG_W * PNG_H);

    // Descriptor field offsets inside the ROM data word
    localparam int unsigned PAGE_LSB   = 0;
    localparam int unsigned LENGTH_LSB = CE;
    localparam int unsigned WIDTH_LSB  = 2 * CE;
    localparam int unsigned Y_LSB      = 3 * CE;
    localparam int unsigned X_LSB      = 4 * CE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DESC = 2'd1,
        PIX  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CE-1:0] x;
        logic [CE-1:0] y;
        logic [CE-1:0] width;
        logic [CE-1:0] length;
        logic [CE-1:0] page;
    } desc_t;

    // Split a raw descriptor word into its fields
    function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
        desc_t d;
        d.page   = raw[PAGE_LSB   +: CE];
        d.length = raw[LENGTH_LSB +: CE];
        d.width  = raw[WIDTH_LSB  +: CE];
        d.y      = raw[Y_LSB      +: CE];
        d.x      = raw[X_LSB      +: CE];
        return d;
    endfunction

endpackage

// File: rtl/glyph_addr_gen.sv
// Glyph rectangle walker: column/row counters and pattern ROM address stepping.
//  clk, rst  : clock, synchronous active-high reset
//  load_i    : start a new glyph at base_i (col=row=0)
//  step_i    : advance one pixel (row-major); otherwise everything holds
//  width_i   : glyph width (used on load and step), length_i: glyph height
//  addr_o    : current pattern address; col_o/row_o: position inside glyph
//  eol_o     : current pixel is the last of its row; last_o: last pixel of glyph
module glyph_addr_gen
    import osd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [PA_W-1:0] base_i,
    input  logic [CE-1:0]   width_i,
    input  logic [CE-1:0]   length_i,
    output logic [PA_W-1:0] addr_o,
    output logic [CE-1:0]   col_o,
    output logic [CE-1:0]   row_o,
    output logic            eol_o,
    output logic            last_o
);

    logic [PA_W-1:0] addr_q, addr_d;
    logic [CE-1:0]   col_q, col_d, row_q, row_d;
    logic            eol_q, eol_d, last_q, last_d;
    logic [CE-1:0]   w_m1, l_m1, col_inc, row_inc;

    // Next position; eol/last are precomputed so they leave as registers
    always_comb begin
        w_m1    = width_i - CE'(1);
        l_m1    = length_i - CE'(1);
        col_inc = col_q + CE'(1);
        row_inc = row_q + CE'(1);
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        eol_d   = eol_q;
        last_d  = last_q;
        if (load_i) begin
            addr_d = base_i;
            col_d  = '0;
            row_d  = '0;
            eol_d  = (w_m1 == '0);
            last_d = (w_m1 == '0) && (l_m1 == '0);
        end else if (step_i) begin
            if (eol_q) begin
                // Wrap to the first column of the next row on the page
                col_d  = '0;
                row_d  = row_inc;
                addr_d = addr_q + PA_W'(PNG_W) - PA_W'(w_m1);
                eol_d  = (w_m1 == '0);
                last_d = (w_m1 == '0) && (row_inc == l_m1);
            end else begin
                col_d  = col_inc;
                addr_d = addr_q + PA_W'(1);
                eol_d  = (col_inc == w_m1);
                last_d = (col_inc == w_m1) && (row_q == l_m1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            eol_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
            row_q  <= row_d;
            eol_q  <= eol_d;
            last_q <= last_d;
        end
    end

    assign addr_o = addr_q;
    assign col_o  = col_q;
    assign row_o  = row_q;
    assign eol_o  = eol_q;
    assign last_o = last_q;

endmodule

// File: rtl/glyph_fetch.sv
// OSD glyph reader: looks up a character descriptor, then streams its pixels.
//  clk, rst                : clock, synchronous active-high reset
//  req_valid/ready/code    : character request handshake
//  data_addr / data_in     : descriptor ROM address and combinational data
//  pattern_addr/pattern_in : pattern ROM address and combinational pixel
//  pix_valid/ready/data    : pixel stream; pix_col/row position, pix_eol/last markers
//  glyph_w / glyph_h       : latched descriptor width/height
//  done / err              : end-of-request pulse, err marks a rejected request
module glyph_fetch
    import osd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CE-1:0]      req_code,
    output logic [DA_W-1:0]    data_addr,
    input  logic [DESC_W-1:0]  data_in,
    output logic [PA_W-1:0]    pattern_addr,
    input  logic [MSB_BPP-1:0] pattern_in,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [MSB_BPP-1:0] pix_data,
    output logic [CE-1:0]      pix_col,
    output logic [CE-1:0]      pix_row,
    output logic               pix_eol,
    output logic               pix_last,
    output logic [CE-1:0]      glyph_w,
    output logic [CE-1:0]      glyph_h,
    output logic               done,
    output logic               err
);

    localparam int unsigned SUM_W = CE + 1;

    state_e            state_q;
    logic              req_ready_q, pix_valid_q, done_q, err_q;
    logic [DA_W-1:0]   data_addr_q;
    logic [CE-1:0]     glyph_w_q, glyph_h_q;

    desc_t             desc;
    logic              code_ok, size_zero, out_of_page;
    logic              accept, load, beat;
    logic [CE-1:0]     code_off, gen_w, gen_l;
    logic [SUM_W-1:0]  x_end, y_end;
    logic [PA_W-1:0]   base_addr;
    logic              gen_last;

    // Request decode and descriptor checks; sums are one bit wider to avoid wrap
    always_comb begin
        desc        = unpack_desc(data_in);
        code_ok     = (req_code >= CE'(FIRST_CHAR)) && (req_code <= CE'(LAST_CHAR));
        code_off    = req_code - CE'(FIRST_CHAR);
        x_end       = {1'b0, desc.x} + {1'b0, desc.width};
        y_end       = {1'b0, desc.y} + {1'b0, desc.length};
        size_zero   = (desc.width == '0) || (desc.length == '0);
        out_of_page = (x_end > SUM_W'(PNG_W)) || (y_end > SUM_W'(PNG_H))
                      || (desc.page >= CE'(PAGES));
        base_addr   = PA_W'(32'(desc.page) * PNG_W * PNG_H
                            + 32'(desc.y) * PNG_W + 32'(desc.x));
        accept      = (state_q == IDLE) && req_valid && req_ready_q;
        load        = (state_q == DESC) && !size_zero && !out_of_page;
        beat        = (state_q == PIX) && pix_valid_q && pix_ready;
        gen_w       = (state_q == DESC) ? desc.width  : glyph_w_q;
        gen_l       = (state_q == DESC) ? desc.length : glyph_h_q;
    end

    glyph_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (beat),
        .base_i   (base_addr),
        .width_i  (gen_w),
        .length_i (gen_l),
        .addr_o   (pattern_addr),
        .col_o    (pix_col),
        .row_o    (pix_row),
        .eol_o    (pix_eol),
        .last_o   (gen_last)
    );

    // Request/stream control FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_addr_q <= '0;
            glyph_w_q   <= '0;
            glyph_h_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (code_ok) begin
                            data_addr_q <= DA_W'(code_off * CE'(DESC_STRIDE));
                            req_ready_q <= 1'b0;
                            state_q     <= DESC;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                DESC: begin
                    glyph_w_q <= desc.width;
                    glyph_h_q <= desc.length;
                    if (size_zero || out_of_page) begin
                        // Empty glyph is a clean finish; out-of-page is an error
                        done_q      <= 1'b1;
                        err_q       <= !size_zero;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        pix_valid_q <= 1'b1;
                        state_q     <= PIX;
                    end
                end
                PIX: begin
                    if (beat && gen_last) begin
                        pix_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign data_addr = data_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pattern_in;
    assign pix_last  = gen_last;
    assign glyph_w   = glyph_w_q;
    assign glyph_h   = glyph_h_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_glyph_fetch.sv
// Self-checking bench for glyph_fetch: ROM models, beat scoreboard, vector table.
module tb_glyph_fetch;
    import osd_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [CE-1:0]      req_code = '0;
    logic [DA_W-1:0]    data_addr;
    logic [DESC_W-1:0]  data_in;
    logic [PA_W-1:0]    pattern_addr;
    logic [MSB_BPP-1:0] pattern_in;
    logic               pix_valid;
    logic               pix_ready = 1'b1;
    logic [MSB_BPP-1:0] pix_data;
    logic [CE-1:0]      pix_col, pix_row;
    logic               pix_eol, pix_last;
    logic [CE-1:0]      glyph_w, glyph_h;
    logic               done, err;

    always #5 clk = ~clk;

    glyph_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_code     (req_code),
        .data_addr    (data_addr),
        .data_in      (data_in),
        .pattern_addr (pattern_addr),
        .pattern_in   (pattern_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_col      (pix_col),
        .pix_row      (pix_row),
        .pix_eol      (pix_eol),
        .pix_last     (pix_last),
        .glyph_w      (glyph_w),
        .glyph_h      (glyph_h),
        .done         (done),
        .err          (err)
    );

    // ROM models
    logic [DESC_W-1:0] rom_desc [0:351];
    int unsigned       rom_idx;

    function automatic logic [MSB_BPP-1:0] pat_fn(input logic [PA_W-1:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
    endfunction

    always_comb begin
        rom_idx = 32'(data_addr) / DESC_STRIDE;
        data_in = (rom_idx <= 351) ? rom_desc[rom_idx[8:0]] : '0;
    end

    always_comb pattern_in = pat_fn(pattern_addr);

    // Optional random back-pressure
    bit stall_en = 1'b0;
    always @(posedge clk) begin
        #1;
        pix_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string info);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, info);
    endtask

    // Scoreboard of expected beats
    typedef struct {
        logic [PA_W-1:0] addr;
        logic [CE-1:0]   col;
        logic [CE-1:0]   row;
        logic            eol;
        logic            last;
    } beat_t;

    beat_t exp_q[$];

    task automatic push_glyph(input int x, input int y, input int w, input int l, input int pg);
        beat_t b;
        for (int r = 0; r < l; r++) begin
            for (int c = 0; c < w; c++) begin
                b.addr = PA_W'(pg * 4096 + (y + r) * 64 + x + c);
                b.col  = CE'(c);
                b.row  = CE'(r);
                b.eol  = (c == w - 1);
                b.last = (c == w - 1) && (r == l - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic set_desc(input int code, input int x, input int y, input int w,
                            input int l, input int pg);
        rom_desc[code - 32] = {CE'(x), CE'(y), CE'(w), CE'(l), CE'(pg)};
    endtask

    // Monitor, sampling on the falling edge
    int    cyc = 0;
    int    beats_seen = 0, pv_cycles = 0, done_cnt = 0, done_cyc = 0, stall_cnt = 0;
    logic  last_err = 1'b0;
    beat_t mb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = err;
            end
            if (pix_valid) begin
                pv_cycles++;
                if (exp_q.size() == 0) begin
                    fail("beat_unexpected", $sformatf("addr=%0d col=%0d row=%0d",
                         pattern_addr, pix_col, pix_row));
                end else begin
                    mb = exp_q[0];
                    check("beat", 64'({pattern_addr, pix_col, pix_row, pix_eol, pix_last, pix_data}),
                          64'({mb.addr, mb.col, mb.row, mb.eol, mb.last, pat_fn(mb.addr)}));
                    if (pix_ready) void'(exp_q.pop_front());
                end
                if (pix_ready) beats_seen++;
                else stall_cnt++;
            end
        end
    end

    task automatic wait_accept(output int edge_no);
        bit got;
        got = 1'b0;
        edge_no = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (got) edge_no = cyc;
        else fail("accept_timeout", "req_ready never seen");
    endtask

    task automatic send(input int code, output int edge_no);
        req_code  = CE'(code);
        req_valid = 1'b1;
        wait_accept(edge_no);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > start) ok = 1'b1;
        end
        if (!ok) fail("done_timeout", "no done pulse");
    endtask

    typedef struct {
        int code;
        int x, y, w, l, pg;
        bit exp_err;
        int beats;
        int daddr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int    e, e1, e2, d0, b0, p0, s0;
        bit    ok, in_range, seen;
        vec_t  v;
        string tag;

        for (int i = 0; i < 352; i++) rom_desc[i] = '0;

        //          code  x   y   w  l  pg err beats daddr
        vecs[0]  = '{65,  8,  0,  3, 2, 1, 0,  6,   198};
        vecs[1]  = '{31,  0,  0,  0, 0, 0, 1,  0,   -1};
        vecs[2]  = '{384, 0,  0,  0, 0, 0, 1,  0,   -1};
        vecs[3]  = '{40,  0,  0,  0, 3, 0, 0,  0,   48};
        vecs[4]  = '{41,  62, 0,  4, 1, 0, 1,  0,   54};
        vecs[5]  = '{42,  0,  0,  2, 0, 0, 0,  0,   60};
        vecs[6]  = '{32,  0,  0,  1, 1, 0, 0,  1,   0};
        vecs[7]  = '{383, 60, 60, 4, 4, 1, 0,  16,  2106};
        vecs[8]  = '{100, 0,  0,  2, 2, 2, 1,  0,   408};
        vecs[9]  = '{101, 0,  63, 1, 2, 0, 1,  0,   414};
        vecs[10] = '{102, 63, 63, 1, 1, 1, 0,  1,   420};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_done_err", 64'({done, err}), 64'(0));
        check("rst_data_addr", 64'(data_addr), 64'(0));
        check("rst_pattern_addr", 64'(pattern_addr), 64'(0));
        check("rst_glyph_wh", 64'({glyph_w, glyph_h}), 64'(0));
        check("rst_col_row", 64'({pix_col, pix_row}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            tag = $sformatf("v%0d_code%0d", i, v.code);
            in_range = (v.code >= 32) && (v.code <= 383);
            if (in_range) set_desc(v.code, v.x, v.y, v.w, v.l, v.pg);
            if (v.beats > 0) push_glyph(v.x, v.y, v.w, v.l, v.pg);
            d0 = done_cnt;
            b0 = beats_seen;
            p0 = pv_cycles;
            send(v.code, e);
            wait_done(d0, ok);
            if (ok) begin
                check({tag, "_err"}, 64'(last_err), 64'(v.exp_err));
                check({tag, "_done_cycle"}, 64'(done_cyc), 64'(e + (in_range ? 1 + v.beats : 0)));
                check({tag, "_beats"}, 64'(beats_seen - b0), 64'(v.beats));
                check({tag, "_valid_cycles"}, 64'(pv_cycles - p0), 64'(v.beats));
                check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
                if (v.daddr >= 0) check({tag, "_data_addr"}, 64'(data_addr), 64'(v.daddr));
                if (in_range) check({tag, "_glyph_wh"}, 64'({glyph_w, glyph_h}),
                                    64'({CE'(v.w), CE'(v.l)}));
            end
            exp_q.delete();
        end

        // 5x4 glyph under random back-pressure
        set_desc(110, 5, 7, 5, 4, 0);
        push_glyph(5, 7, 5, 4, 0);
        stall_en = 1'b1;
        d0 = done_cnt;
        b0 = beats_seen;
        s0 = stall_cnt;
        send(110, e);
        wait_done(d0, ok);
        stall_en = 1'b0;
        check("stall_beats", 64'(beats_seen - b0), 64'(20));
        check("stall_sb_empty", 64'(exp_q.size()), 64'(0));
        check("stall_err", 64'(last_err), 64'(0));
        check("stall_seen", 64'(stall_cnt > s0), 64'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back requests with req_valid held
        set_desc(70, 0, 0, 2, 2, 0);
        set_desc(71, 10, 20, 3, 1, 1);
        push_glyph(0, 0, 2, 2, 0);
        push_glyph(10, 20, 3, 1, 1);
        d0 = done_cnt;
        b0 = beats_seen;
        req_code  = CE'(70);
        req_valid = 1'b1;
        wait_accept(e1);
        req_code = CE'(71);
        wait_accept(e2);
        req_valid = 1'b0;
        check("b2b_accept_edge", 64'(e2), 64'(e1 + 6));
        check("b2b_done1_cycle", 64'(done_cyc), 64'(e2 - 1));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pix_valid) seen = 1'b1;
        end
        if (seen) check("b2b_first_beat_cycle", 64'(cyc), 64'(e2 + 1));
        else fail("b2b_first_beat", "pix_valid never seen");
        @(posedge clk);
        #1;
        wait_done(d0 + 1, ok);
        check("b2b_done2_cycle", 64'(done_cyc), 64'(e2 + 4));
        check("b2b_beats", 64'(beats_seen - b0), 64'(7));
        check("b2b_sb_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();

        // Reset during beat 3 of a 3x2 glyph, then a clean restart
        push_glyph(8, 0, 3, 2, 1);
        d0 = done_cnt;
        b0 = beats_seen;
        send(65, e);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_req_ready", 64'(req_ready), 64'(1));
        check("rst_mid_beats", 64'(beats_seen - b0), 64'(2));
        exp_q.delete();
        @(posedge clk);
        #1;
        push_glyph(8, 0, 3, 2, 1);
        b0 = beats_seen;
        send(65, e);
        wait_done(d0, ok);
        check("restart_done_count", 64'(done_cnt), 64'(d0 + 1));
        check("restart_done_cycle", 64'(done_cyc), 64'(e + 7));
        check("restart_beats", 64'(beats_seen - b0), 64'(6));
        check("restart_sb_empty", 64'(exp_q.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
